// File: rtl/param_cpu_core.sv
// param_cpu_core: three-state (FETCH/EXEC/WB) register-machine core with a
// parameterisable datapath width and register-file depth. One instruction
// completes every three cycles while run is held high.
module param_cpu_core #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned REG_COUNT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [31:0]       instr_data,
  output logic [31:0]       pc,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              illegal
);

  localparam int unsigned ADDR_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_AND   = 8'h02;
  localparam logic [7:0] OP_OR    = 8'h03;
  localparam logic [7:0] OP_MOV   = 8'h08;
  localparam logic [7:0] OP_SUB   = 8'h09;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t              state;
  logic [31:0]         ir;
  logic                wb_legal;
  logic [DATA_W-1:0]   regs [REG_COUNT];

  logic [7:0]          opcode;
  logic [7:0]          imm;
  logic [ADDR_W-1:0]   dest_idx;
  logic [ADDR_W-1:0]   src1_idx;
  logic [ADDR_W-1:0]   src2_idx;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]   alu_val;
  logic                op_legal;

  // Field extraction; register indices keep only the low ADDR_W bits.
  always_comb begin
    opcode   = ir[31:24];
    imm      = ir[7:0];
    dest_idx = ADDR_W'(ir[23:16]);
    src1_idx = ADDR_W'(ir[15:8]);
    src2_idx = ADDR_W'(ir[7:0]);
    op_a     = regs[src1_idx];
    op_b     = regs[src2_idx];
  end

  // ALU and opcode legality decode.
  always_comb begin
    alu_val  = '0;
    op_legal = 1'b1;
    case (opcode)
      OP_LOADI: alu_val[7:0] = imm;
      OP_ADD:   alu_val = op_a + op_b;
      OP_AND:   alu_val = op_a & op_b;
      OP_OR:    alu_val = op_a | op_b;
      OP_MOV:   alu_val = op_b;
      OP_SUB:   alu_val = op_a - op_b;
      default:  op_legal = 1'b0;
    endcase
  end

  // Control FSM with registered outputs: result and result_valid are loaded
  // on the EXEC->WB edge so the pulse coincides with the WB cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      ir           <= '0;
      pc           <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      illegal      <= 1'b0;
      wb_legal     <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          result_valid <= 1'b0;
          if (run) begin
            ir    <= instr_data;
            state <= EXEC;
          end
        end
        EXEC: begin
          wb_legal     <= op_legal;
          result_valid <= op_legal;
          if (op_legal) begin
            result <= alu_val;
          end
          state <= WB;
        end
        WB: begin
          result_valid <= 1'b0;
          if (!wb_legal) begin
            illegal <= 1'b1;
          end
          pc    <= pc + 32'd4;
          state <= FETCH;
        end
        default: begin
          result_valid <= 1'b0;
          state        <= FETCH;
        end
      endcase
    end
  end

  // Register file write-back; the write lands on the edge that leaves WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (state == WB && wb_legal) begin
      regs[dest_idx] <= result;
    end
  end

endmodule

// File: tb/tb_param_cpu_core.sv
// Directed self-checking bench for param_cpu_core: an 8-bit/8-register core
// and a 16-bit/16-register core run in lockstep from separate program memories.
module tb_param_cpu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;

  logic [31:0] prog   [64];
  logic [31:0] prog_w [64];

  logic [31:0] instr_data, instr_data_w;
  logic [31:0] pc, pc_w;
  logic [7:0]  result;
  logic [15:0] result_w;
  logic        result_valid, result_valid_w;
  logic        illegal, illegal_w;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pulses   [$];
  int          pulse_cyc[$];
  logic [15:0] pulses_w [$];

  assign instr_data   = prog[pc[7:2]];
  assign instr_data_w = prog_w[pc_w[7:2]];

  always #5 clk = ~clk;

  param_cpu_core #(.DATA_W(8), .REG_COUNT(8)) dut (
    .clk(clk), .reset(reset), .run(run), .instr_data(instr_data),
    .pc(pc), .result(result), .result_valid(result_valid), .illegal(illegal)
  );

  param_cpu_core #(.DATA_W(16), .REG_COUNT(16)) dut_w (
    .clk(clk), .reset(reset), .run(run), .instr_data(instr_data_w),
    .pc(pc_w), .result(result_w), .result_valid(result_valid_w), .illegal(illegal_w)
  );

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s2);
    return {op, d, s1, s2};
  endfunction

  task automatic clear_progs();
    for (int i = 0; i < 64; i++) begin
      prog[i]   = 32'h0;
      prog_w[i] = 32'h0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    run   = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs n instructions from FETCH with run high, dropping run during the
  // last WB so the core parks in FETCH. Called at a negedge.
  task automatic run_instrs(input int n);
    pulses.delete();
    pulse_cyc.delete();
    pulses_w.delete();
    run = 1'b1;
    for (int c = 1; c <= 3 * n; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (result_valid) begin
        pulses.push_back(result);
        pulse_cyc.push_back(c);
      end
      if (result_valid_w) pulses_w.push_back(result_w);
      if (c == 3 * n - 1) run = 1'b0;
    end
  endtask

  task automatic test_reset();
    clear_progs();
    #2;
    reset = 1'b1;
    #1;
    if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++;
    if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %h exp %h", result, 8'h00); end
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", result_valid); end
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    checks++;
    if (pc_w !== 32'h0 || result_w !== 16'h0) begin
      errors++; $display("FAIL reset_wide got pc %h res %h exp 0 0", pc_w, result_w);
    end
    checks++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sequence();
    logic [7:0] exp [8] = '{8'hFF, 8'hAA, 8'hBB, 8'h65, 8'h65, 8'hEF, 8'hEF, 8'h34};
    clear_progs();
    prog[0] = ins(8'h00, 8'd4, 8'd0, 8'hFF);
    prog[1] = ins(8'h00, 8'd6, 8'd0, 8'hAA);
    prog[2] = ins(8'h00, 8'd3, 8'd0, 8'hBB);
    prog[3] = ins(8'h01, 8'd5, 8'd6, 8'd3);
    prog[4] = ins(8'h02, 8'd1, 8'd4, 8'd5);
    prog[5] = ins(8'h03, 8'd2, 8'd1, 8'd6);
    prog[6] = ins(8'h08, 8'd7, 8'd0, 8'd2);
    prog[7] = ins(8'h09, 8'd4, 8'd7, 8'd3);
    do_reset();
    run_instrs(8);
    if (pulses.size() !== 8) begin errors++; $display("FAIL seq_pulse_count got %0d exp 8", pulses.size()); end
    checks++;
    for (int k = 0; k < 8 && k < pulses.size(); k++) begin
      if (pulses[k] !== exp[k]) begin errors++; $display("FAIL seq_result[%0d] got %h exp %h", k, pulses[k], exp[k]); end
      checks++;
      if (pulse_cyc[k] !== 3 * k + 2) begin errors++; $display("FAIL seq_latency[%0d] got %0d exp %0d", k, pulse_cyc[k], 3 * k + 2); end
      checks++;
    end
    if (pc !== 32'h20) begin errors++; $display("FAIL seq_pc got %h exp %h", pc, 32'h20); end
    checks++;
  endtask

  task automatic test_wrap();
    logic [7:0] exp [5] = '{8'h01, 8'h02, 8'hFF, 8'h00, 8'h02};
    clear_progs();
    prog[0] = ins(8'h00, 8'd0, 8'd0, 8'h01);
    prog[1] = ins(8'h00, 8'd1, 8'd0, 8'h02);
    prog[2] = ins(8'h09, 8'd2, 8'd0, 8'd1);
    prog[3] = ins(8'h01, 8'd3, 8'd2, 8'd0);
    prog[4] = ins(8'h08, 8'h0C, 8'h00, 8'h09); // mov r4, r1 via upper-bit-laden fields
    do_reset();
    run_instrs(5);
    if (pulses.size() !== 5) begin errors++; $display("FAIL wrap_pulse_count got %0d exp 5", pulses.size()); end
    checks++;
    for (int k = 0; k < 5 && k < pulses.size(); k++) begin
      if (pulses[k] !== exp[k]) begin errors++; $display("FAIL wrap_result[%0d] got %h exp %h", k, pulses[k], exp[k]); end
      checks++;
    end
  endtask

  task automatic test_illegal();
    clear_progs();
    prog[0] = ins(8'h00, 8'd2, 8'd0, 8'h5A);
    prog[1] = ins(8'h07, 8'd2, 8'd0, 8'h11);
    prog[2] = ins(8'h08, 8'd3, 8'd0, 8'd2);
    prog[3] = ins(8'h00, 8'd4, 8'd0, 8'h33);
    do_reset();
    run_instrs(1);
    if (illegal !== 1'b0) begin errors++; $display("FAIL ill_before got %b exp 0", illegal); end
    checks++;
    run_instrs(1);
    if (illegal !== 1'b1) begin errors++; $display("FAIL ill_set got %b exp 1", illegal); end
    checks++;
    if (pulses.size() !== 0) begin errors++; $display("FAIL ill_no_pulse got %0d exp 0", pulses.size()); end
    checks++;
    if (pc !== 32'h8) begin errors++; $display("FAIL ill_pc got %h exp %h", pc, 32'h8); end
    checks++;
    if (result !== 8'h5A) begin errors++; $display("FAIL ill_result_held got %h exp 5a", result); end
    checks++;
    run_instrs(2);
    if (pulses.size() !== 2) begin
      errors++; $display("FAIL ill_after_count got %0d exp 2", pulses.size());
    end else begin
      if (pulses[0] !== 8'h5A) begin errors++; $display("FAIL ill_reg_unchanged got %h exp 5a", pulses[0]); end
      checks++;
      if (pulses[1] !== 8'h33) begin errors++; $display("FAIL ill_next_loadi got %h exp 33", pulses[1]); end
    end
    checks++;
    if (illegal !== 1'b1) begin errors++; $display("FAIL ill_sticky got %b exp 1", illegal); end
    checks++;
  endtask

  task automatic test_stall();
    int bad;
    clear_progs();
    prog[0] = ins(8'h00, 8'd1, 8'd0, 8'h77);
    prog[1] = ins(8'h00, 8'd2, 8'd0, 8'h12);
    do_reset();
    run_instrs(1);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (pc !== 32'h4 || result !== 8'h77 || result_valid !== 1'b0) bad++;
    end
    if (bad !== 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles exp 0 (pc %h res %h)", bad, pc, result); end
    checks++;
    run_instrs(1);
    if (pulses.size() !== 1 || pulse_cyc[0] !== 2 || pulses[0] !== 8'h12) begin
      errors++; $display("FAIL stall_resume got %0d pulses exp 1 pulse of 12 at cycle 2", pulses.size());
    end
    checks++;
  endtask

  task automatic test_reset_in_wb();
    clear_progs();
    prog[0] = ins(8'h00, 8'd6, 8'd0, 8'h10);
    prog[1] = ins(8'h00, 8'd3, 8'd0, 8'h20);
    prog[2] = ins(8'h01, 8'd5, 8'd6, 8'd3);
    do_reset();
    run_instrs(2);
    run = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    if (result_valid !== 1'b1 || result !== 8'h30) begin
      errors++; $display("FAIL rwb_in_wb got v %b res %h exp 1 30", result_valid, result);
    end
    checks++;
    run   = 1'b0;
    reset = 1'b1;
    #1;
    if (pc !== 32'h0 || result !== 8'h0 || result_valid !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL rwb_async got pc %h res %h v %b ill %b exp 0 0 0 0", pc, result, result_valid, illegal);
    end
    checks++;
    @(posedge clk); #1;
    if (pc !== 32'h0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL rwb_held got pc %h v %b exp 0 0", pc, result_valid);
    end
    checks++;
    @(negedge clk);
    reset = 1'b0;
    prog[0] = ins(8'h08, 8'd0, 8'd0, 8'd5);
    run_instrs(1);
    if (pulses.size() !== 1 || pulses[0] !== 8'h00 || pc !== 32'h4) begin
      errors++; $display("FAIL rwb_r5 got %0d pulses pc %h exp r5=00 pc 4", pulses.size(), pc);
    end
    checks++;
  endtask

  task automatic test_wide();
    logic [15:0] exp [5] = '{16'h00FF, 16'h01FE, 16'h0042, 16'h0042, 16'h03FC};
    clear_progs();
    prog_w[0] = ins(8'h00, 8'h0F, 8'h00, 8'hFF);
    prog_w[1] = ins(8'h01, 8'h0E, 8'h0F, 8'h0F);
    prog_w[2] = ins(8'h00, 8'h1F, 8'h00, 8'h42);
    prog_w[3] = ins(8'h08, 8'h00, 8'h00, 8'h0F);
    prog_w[4] = ins(8'h01, 8'h01, 8'h0E, 8'h0E);
    do_reset();
    run_instrs(5);
    if (pulses_w.size() !== 5) begin errors++; $display("FAIL wide_count got %0d exp 5", pulses_w.size()); end
    checks++;
    for (int k = 0; k < 5 && k < pulses_w.size(); k++) begin
      if (pulses_w[k] !== exp[k]) begin errors++; $display("FAIL wide_result[%0d] got %h exp %h", k, pulses_w[k], exp[k]); end
      checks++;
    end
    if (pc_w !== 32'h14) begin errors++; $display("FAIL wide_pc got %h exp %h", pc_w, 32'h14); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_wrap();
    test_illegal();
    test_stall();
    test_reset_in_wb();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
